// File: rtl/mem_halfword_load_if.sv
// Data-memory read bus between the half-word load unit and data memory.
//   memReq  : request, held for the whole access
//   memAddr : word-aligned byte address
//   memAck  : read data valid this cycle
//   memData : little-endian read word
// master = load unit side, slave = memory side.
interface mem_halfword_load_if;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memData;

    modport master (
        output memReq,
        output memAddr,
        input  memAck,
        input  memData
    );

    modport slave (
        input  memReq,
        input  memAddr,
        output memAck,
        output memData
    );
endinterface

// File: rtl/mem_halfword_load.sv
// Memory-stage half-word load unit.
// Takes a half-word load from EX/MEM, issues a word-aligned read on the memory
// bus, picks the addressed 16-bit half of the returned word and hands it, with
// the captured sign/zero select, to the downstream extender. Stalls the
// pipeline while the access is outstanding; flags misaligned loads and
// accesses that receive no ack within TIMEOUT request cycles.
// Ports:
//   clk, reset_n            : clock (rising edge), async active-low reset
//   loadReq/loadAddr        : load request and byte address from EX/MEM
//   SIG_ExtHalf             : 1 = sign extend, 0 = zero extend
//   mem                     : memory read bus (master side)
//   halfWord/SIG_ExtHalfOut : selected half word and extend select to extender
//   halfValid               : one-cycle pulse, halfWord is new
//   stall                   : freezes the upstream pipeline
//   alignErr/timeoutErr     : one-cycle error pulses
module mem_halfword_load #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        loadReq,
    input  logic [31:0]                 loadAddr,
    input  logic                        SIG_ExtHalf,
    mem_halfword_load_if.master         mem,
    output logic [15:0]                 halfWord,
    output logic                        SIG_ExtHalfOut,
    output logic                        halfValid,
    output logic                        stall,
    output logic                        alignErr,
    output logic                        timeoutErr
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e             state_q, state_d;
    // Bit 0 of an accepted address is always 0, so it is not stored.
    logic [31:1]        addr_q, addr_d;
    logic               ext_sel_q, ext_sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        half_q, half_d;
    logic               ext_out_q, ext_out_d;
    logic               align_err_q, align_err_d;
    logic               timeout_err_q, timeout_err_d;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        ext_sel_d     = ext_sel_q;
        cnt_d         = cnt_q;
        half_d        = half_q;
        ext_out_d     = ext_out_q;
        align_err_d   = 1'b0;
        timeout_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (loadReq) begin
                    if (loadAddr[0]) begin
                        align_err_d = 1'b1;
                    end else begin
                        addr_d    = loadAddr[31:1];
                        ext_sel_d = SIG_ExtHalf;
                        cnt_d     = '0;
                        state_d   = StReq;
                    end
                end
            end
            StReq: begin
                if (mem.memAck) begin
                    half_d    = addr_q[1] ? mem.memData[31:16] : mem.memData[15:0];
                    ext_out_d = ext_sel_q;
                    state_d   = StDone;
                end else if (cnt_q == CntLast) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // loadReq here still belongs to the retiring load, so it is ignored.
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            ext_sel_q     <= 1'b0;
            cnt_q         <= '0;
            half_q        <= '0;
            ext_out_q     <= 1'b0;
            align_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            ext_sel_q     <= ext_sel_d;
            cnt_q         <= cnt_d;
            half_q        <= half_d;
            ext_out_q     <= ext_out_d;
            align_err_q   <= align_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        mem.memReq     = (state_q == StReq);
        mem.memAddr    = (state_q == StReq) ? {addr_q[31:2], 2'b00} : 32'h0;
        halfWord       = half_q;
        SIG_ExtHalfOut = ext_out_q;
        halfValid      = (state_q == StDone);
        alignErr       = align_err_q;
        timeoutErr     = timeout_err_q;
        // Gated by reset so the pipeline is never frozen while reset is held.
        stall          = reset_n &
                         (((state_q == StIdle) & loadReq & ~loadAddr[0]) | (state_q == StReq));
    end

endmodule

// File: tb/tb_mem_halfword_load.sv
module tb_mem_halfword_load;

    logic        clk;
    logic        reset_n;
    logic        loadReq;
    logic [31:0] loadAddr;
    logic        SIG_ExtHalf;
    logic [15:0] halfWord;
    logic        SIG_ExtHalfOut;
    logic        halfValid;
    logic        stall;
    logic        alignErr;
    logic        timeoutErr;

    int checks = 0;
    int errors = 0;

    mem_halfword_load_if mem_if ();

    mem_halfword_load #(
        .TIMEOUT (16),
        .CNT_W   (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .loadReq        (loadReq),
        .loadAddr       (loadAddr),
        .SIG_ExtHalf    (SIG_ExtHalf),
        .mem            (mem_if),
        .halfWord       (halfWord),
        .SIG_ExtHalfOut (SIG_ExtHalfOut),
        .halfValid      (halfValid),
        .stall          (stall),
        .alignErr       (alignErr),
        .timeoutErr     (timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        sext;
        int          ack_cyc;   // REQ cycle (1-based) in which memAck is given
        logic [31:0] data;
        logic [31:0] exp_maddr;
        logic [15:0] exp_half;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full load: acceptance cycle, ack_cyc REQ cycles, then DONE.
    // loadReq is left high on return so back-to-back loads can follow directly.
    task automatic do_load(input vec_t v);
        @(posedge clk); #1;
        loadReq     = 1'b1;
        loadAddr    = v.addr;
        SIG_ExtHalf = v.sext;
        mem_if.memAck = 1'b0;
        @(negedge clk);
        check("accept_stall", {31'b0, stall}, 32'd1);
        check("accept_memreq", {31'b0, mem_if.memReq}, 32'd0);
        for (int c = 1; c <= v.ack_cyc; c++) begin
            @(posedge clk); #1;
            mem_if.memAck  = (c == v.ack_cyc);
            mem_if.memData = v.data;
            @(negedge clk);
            check("req_memreq", {31'b0, mem_if.memReq}, 32'd1);
            check("req_memaddr", mem_if.memAddr, v.exp_maddr);
            check("req_stall", {31'b0, stall}, 32'd1);
            check("req_halfvalid", {31'b0, halfValid}, 32'd0);
        end
        @(posedge clk); #1;
        mem_if.memAck = 1'b0;
        @(negedge clk);
        check("done_halfvalid", {31'b0, halfValid}, 32'd1);
        check("done_halfword", {16'b0, halfWord}, {16'b0, v.exp_half});
        check("done_sext", {31'b0, SIG_ExtHalfOut}, {31'b0, v.sext});
        check("done_stall", {31'b0, stall}, 32'd0);
        check("done_memreq", {31'b0, mem_if.memReq}, 32'd0);
        check("done_errs", {30'b0, alignErr, timeoutErr}, 32'd0);
    endtask

    int req_cycles;

    initial begin
        vecs[0] = '{32'h0000_0000, 1'b1, 2, 32'h8001_7FFE, 32'h0000_0000, 16'h7FFE};
        vecs[1] = '{32'hFFFF_FFFE, 1'b0, 1, 32'hBEEF_1234, 32'hFFFF_FFFC, 16'hBEEF};
        vecs[2] = '{32'h0000_0100, 1'b1, 3, 32'h3F3F_FFFF, 32'h0000_0100, 16'hFFFF};
        vecs[3] = '{32'h0000_0102, 1'b0, 1, 32'h3F3F_0000, 32'h0000_0100, 16'h3F3F};
        vecs[4] = '{32'h0000_0206, 1'b1, 4, 32'hC0DE_0000, 32'h0000_0204, 16'hC0DE};

        reset_n        = 1'b0;
        loadReq        = 1'b0;
        loadAddr       = 32'h0;
        SIG_ExtHalf    = 1'b0;
        mem_if.memAck  = 1'b0;
        mem_if.memData = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_memreq", {31'b0, mem_if.memReq}, 32'd0);
        check("rst_memaddr", mem_if.memAddr, 32'h0);
        check("rst_halfword", {16'b0, halfWord}, 32'h0);
        check("rst_flags", {27'b0, SIG_ExtHalfOut, halfValid, stall, alignErr, timeoutErr},
              32'h0);
        reset_n = 1'b1;

        // Table-driven loads; vecs[3] must be last so halfWord ends at 0x3F3F.
        vecs[4] = vecs[3];
        vecs[3] = '{32'h0000_0206, 1'b1, 4, 32'hC0DE_0000, 32'h0000_0204, 16'hC0DE};
        for (int i = 0; i < 5; i++) begin
            do_load(vecs[i]);
            @(posedge clk); #1;
            loadReq = 1'b0;
        end

        // Misaligned load, with a stray memAck that must be ignored in IDLE.
        loadReq        = 1'b1;
        loadAddr       = 32'h0000_0101;
        mem_if.memAck  = 1'b1;
        mem_if.memData = 32'h1111_2222;
        @(negedge clk);
        check("mis_stall", {31'b0, stall}, 32'd0);
        check("mis_memreq0", {31'b0, mem_if.memReq}, 32'd0);
        check("mis_alignerr0", {31'b0, alignErr}, 32'd0);
        @(posedge clk); #1;
        loadReq       = 1'b0;
        mem_if.memAck = 1'b0;
        @(negedge clk);
        check("mis_alignerr1", {31'b0, alignErr}, 32'd1);
        check("mis_memreq1", {31'b0, mem_if.memReq}, 32'd0);
        check("mis_halfword", {16'b0, halfWord}, 32'h3F3F);
        check("mis_halfvalid", {31'b0, halfValid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mis_alignerr2", {31'b0, alignErr}, 32'd0);
        check("mis_memreq2", {31'b0, mem_if.memReq}, 32'd0);

        // Timeout: no ack for 16 REQ cycles.
        @(posedge clk); #1;
        loadReq  = 1'b1;
        loadAddr = 32'h0000_0300;
        req_cycles = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (mem_if.memReq === 1'b1) req_cycles++;
            check("to_nohv", {30'b0, halfValid, timeoutErr}, 32'd0);
        end
        @(posedge clk); #1;
        loadReq = 1'b0;
        @(negedge clk);
        check("to_req_cycles", req_cycles, 32'd16);
        check("to_memreq_off", {31'b0, mem_if.memReq}, 32'd0);
        check("to_err", {31'b0, timeoutErr}, 32'd1);
        check("to_halfvalid", {31'b0, halfValid}, 32'd0);
        check("to_halfword", {16'b0, halfWord}, 32'h3F3F);
        @(posedge clk); #1;
        @(negedge clk);
        check("to_err_pulse", {31'b0, timeoutErr}, 32'd0);

        // Reset in the middle of REQ.
        @(posedge clk); #1;
        loadReq  = 1'b1;
        loadAddr = 32'h0000_0400;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_memreq_pre", {31'b0, mem_if.memReq}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_memreq", {31'b0, mem_if.memReq}, 32'd0);
        check("mid_memaddr", mem_if.memAddr, 32'h0);
        check("mid_halfword", {16'b0, halfWord}, 32'h0);
        check("mid_flags", {27'b0, SIG_ExtHalfOut, halfValid, stall, alignErr, timeoutErr},
              32'h0);
        loadReq = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        do_load('{32'h0000_0200, 1'b0, 2, 32'h1234_5678, 32'h0000_0200, 16'h5678});
        @(posedge clk); #1;
        loadReq = 1'b0;

        // Back-to-back loads with loadReq never dropped.
        do_load('{32'h0000_0104, 1'b1, 1, 32'hAAAA_5555, 32'h0000_0104, 16'h5555});
        do_load('{32'h0000_0106, 1'b1, 1, 32'hAAAA_5555, 32'h0000_0104, 16'hAAAA});
        @(posedge clk); #1;
        loadReq = 1'b0;
        @(negedge clk);
        check("b2b_idle", {29'b0, mem_if.memReq, halfValid, stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound so the run always ends even if a sequence misbehaves.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
